// File: rtl/ft_pkg.sv
// ft_pkg: shared types and debug-space addresses for the fault-tolerance recovery path
package ft_pkg;
  typedef enum logic [2:0] {IDLE, HALT, WR_GPR, WR_NPC, RESUME, WAIT_RUN} ft_rec_state_e;
  localparam logic [14:0] DBG_GPR_BASE = 15'h400;
  localparam logic [14:0] DBG_NPC_ADDR = 15'h2000;
endpackage

// File: rtl/ft_dual_grant.sv
// ft_dual_grant: per-core debug req/gnt handshake tracker for two lockstep cores
// Ports: clk_i/rst_ni clock and async active-low reset; start_i raises both requests
// and clears the done flags; clear_i drops everything; dbg_gnt_i per-core grants;
// dbg_req_o per-core requests; all_done_o both cores granted (including this cycle).
module ft_dual_grant (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       clear_i,
  input  logic [1:0] dbg_gnt_i,
  output logic [1:0] dbg_req_o,
  output logic       all_done_o
);
  logic [1:0] req_q, req_d, done_q, done_d;
  always_comb begin
    req_d  = start_i ? 2'b11 : clear_i ? 2'b00 : req_q & ~dbg_gnt_i;
    done_d = (start_i | clear_i) ? 2'b00 : done_q | (req_q & dbg_gnt_i);
  end
  // A grant seen this cycle already counts, so the FSM can advance without a bubble.
  assign all_done_o = &(done_q | (req_q & dbg_gnt_i));
  assign dbg_req_o  = req_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_q  <= 2'b00;
      done_q <= 2'b00;
    end else begin
      req_q  <= req_d;
      done_q <= done_d;
    end
  end
endmodule

// File: rtl/ft_recovery_seq.sv
// ft_recovery_seq: halts both lockstep cores, restores one GPR and the NPC over debug, resumes
// Ports: clk_i/rst_ni clock and async active-low reset; rec_* recovery request handshake
// and payload; dbg_halt_o/dbg_resume_o/dbg_halted_i core run control; dbg_req_o/dbg_gnt_i
// per-core debug handshake with shared dbg_we_o/dbg_addr_o/dbg_wdata_o; busy_o not idle;
// err_o sticky halt/run timeout; rec_count_o saturating count of completed recoveries.
module ft_recovery_seq import ft_pkg::*; #(
  parameter int HALT_TIMEOUT = 64,
  parameter int CNT_W        = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             rec_valid_i,
  output logic             rec_ready_o,
  input  logic [4:0]       rec_addr_i,
  input  logic [31:0]      rec_data_i,
  input  logic [31:0]      rec_pc_i,
  output logic             dbg_halt_o,
  output logic             dbg_resume_o,
  input  logic [1:0]       dbg_halted_i,
  output logic [1:0]       dbg_req_o,
  input  logic [1:0]       dbg_gnt_i,
  output logic             dbg_we_o,
  output logic [14:0]      dbg_addr_o,
  output logic [31:0]      dbg_wdata_o,
  output logic             busy_o,
  output logic             err_o,
  output logic [CNT_W-1:0] rec_count_o
);
  localparam int TW = $clog2(HALT_TIMEOUT + 1);
  ft_rec_state_e state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0] addr_q;
  logic [31:0] data_q, pc_q;
  logic err_q, err_d, accept, tmo_hit, all_done, start, clear;
  assign accept  = rec_valid_i & (state_q == IDLE);
  assign tmo_hit = tmo_q == TW'(HALT_TIMEOUT - 1);
  // Halt/run checks come before the timeout so a same-cycle halt wins.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    case (state_q)
      IDLE:     state_d = accept ? HALT : IDLE;
      HALT:
        if (dbg_halted_i == 2'b11) state_d = (addr_q == 5'd0) ? WR_NPC : WR_GPR;
        else if (tmo_hit) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      WR_GPR:   state_d = all_done ? WR_NPC : WR_GPR;
      WR_NPC:   state_d = all_done ? RESUME : WR_NPC;
      RESUME:   state_d = WAIT_RUN;
      WAIT_RUN:
        if (dbg_halted_i == 2'b00) state_d = IDLE;
        else if (tmo_hit) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      default:  state_d = IDLE;
    endcase
  end
  assign tmo_d = (state_d != state_q) ? '0 : tmo_q + TW'(1);
  assign cnt_d = (state_q == RESUME && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
  assign start = (state_d != state_q) && (state_d inside {WR_GPR, WR_NPC});
  assign clear = !(state_d inside {WR_GPR, WR_NPC});
  ft_dual_grant u_grant (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .start_i   (start),
    .clear_i   (clear),
    .dbg_gnt_i (dbg_gnt_i),
    .dbg_req_o (dbg_req_o),
    .all_done_o(all_done)
  );
  assign rec_ready_o  = state_q == IDLE;
  assign busy_o       = state_q != IDLE;
  assign dbg_halt_o   = state_q == HALT;
  assign dbg_resume_o = state_q == RESUME;
  assign dbg_we_o     = state_q inside {WR_GPR, WR_NPC};
  assign dbg_addr_o   = (state_q == WR_GPR) ? DBG_GPR_BASE + {8'd0, addr_q, 2'b00} :
                        (state_q == WR_NPC) ? DBG_NPC_ADDR : '0;
  assign dbg_wdata_o  = (state_q == WR_GPR) ? data_q : (state_q == WR_NPC) ? pc_q : '0;
  assign err_o        = err_q;
  assign rec_count_o  = cnt_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      tmo_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      if (accept) begin
        addr_q <= rec_addr_i;
        data_q <= rec_data_i;
        pc_q   <= rec_pc_i;
      end
    end
  end
endmodule
